sfu_requant: RTL and testbench
==============================

Name: sfu_requant

Overview:
- Downstream neighbour of the SFU bias-add stage. Consumes its 8-lane 32-bit `dst_valid`/`dst_*` output, one beat per cycle.
- Per lane: fixed-point multiply, round-shift, zero-point add, saturate to int8.
- Results pack into one 64-bit word per beat and are buffered in a small FIFO behind a valid/ready interface toward the SFU writeback.
- The bias-add stage has no backpressure. This block therefore exports an almost-full stall so the SFU controller can drop `enable` in time.

Parameters:
- LANES, 8: number of lanes per beat (fixed by the bias-add interface).
- IN_W, 32: input lane width, signed.
- OUT_W, 8: output lane width, signed.
- SCALE_W, 16: multiplier width, signed.
- FIFO_DEPTH, 4: output FIFO entries; legal range 4..16.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  pipeline advance; 0 freezes stages S1–S3.
- src_valid  in  1  input beat valid (driven by bias-add `dst_valid`).
- src_0 .. src_7  in  32 each  signed lane inputs (driven by bias-add `dst_0..7`).
- scale  in  16  signed multiplier; quasi-static.
- shift  in  5  right-shift amount 0..31; quasi-static.
- zero_point  in  8  signed output offset; quasi-static.
- dst_valid  out  1  FIFO head valid.
- dst_ready  in  1  consumer accepts the head.
- dst_data  out  64  lane i occupies bits [8i+7:8i].
- src_stall  out  1  FIFO count ≥ FIFO_DEPTH−3; upstream must deassert `enable`/`src_valid`.
- busy  out  1  any stage valid or FIFO non-empty.
- overflow  out  1  sticky; a beat was dropped because the FIFO was full.

Behaviour:
- Reset (`rst`=1 at a clock edge):
  - All stage valids and FIFO count cleared; read and write pointers to 0.
  - `dst_valid`=0, `dst_data`=0, `src_stall`=0, `busy`=0, `overflow`=0.
  - Reset mid-operation discards all in-flight and buffered beats.
- Pipeline: three stages, each advancing only when `enable`=1.
  - S1 captures `src_valid` and the lanes, and computes p = src × scale (48-bit signed).
  - S2: if shift==0, r=p; else r = (p + 2^(shift−1)) >>> shift (arithmetic, round half up).
  - S2 then computes v = r + sign-extended zero_point.
  - S3 saturates v to [−128, 127], packs the lanes, and pushes to the FIFO.
- Latency: `src_valid` beat at edge N is pushed at edge N+3 when `enable` is held at 1. The earliest `dst_valid` is the cycle after that push.
- While `enable`=0:
  - Stages hold their contents and `src_valid` is ignored.
  - The FIFO read side keeps operating.
- FIFO:
  - Push when an S3 beat advances.
  - Pop when `dst_valid` && `dst_ready`.
  - Push and pop in the same cycle leave the count unchanged, including when full.
  - Push while full with no pop: the beat is dropped, `overflow` sets and stays at 1 until `rst`.
  - Pointers wrap modulo FIFO_DEPTH.
  - `dst_data` holds its value while `dst_valid`=1 and `dst_ready`=0.
- `src_stall` is registered from the post-update count. The threshold reserves room for the 3 in-flight beats.
- `scale`, `shift` and `zero_point` may change only while `busy`=0. If they change while `busy`=1, results are undefined but the handshake stays legal.

Optional Feature:
- Macro `SFU_REQUANT_RELU_EN`.
- Defined:
  - Adds input port `relu_en` (1 bit, quasi-static).
  - When `relu_en`=1, the S3 lower clamp bound becomes `zero_point` instead of −128, giving ReLU in the quantized domain.
  - When `relu_en`=0, behaviour is identical to the undefined case.
- Undefined: no `relu_en` port; lower bound is always −128.

Test Plan:
- Basic path:
  - Setup: scale=1, shift=0, zp=0; one beat with src_i = i−4; `dst_ready`=1.
  - Expected: `dst_valid` one cycle after the edge-N+3 push; `dst_data` = 0x03020100FFFEFDFC.
- Rounding:
  - Setup: scale=3, shift=2; lanes 5, −5, 6, 2, 0, 0, 0, 0.
  - Expected (p = 15, −15, 18, 6): r = 4, −4, 5, 2; remaining lanes 0.
- Saturation:
  - Setup: scale=0x7FFF, shift=0, zp=10; lanes +1000, −1000.
  - Expected: lane outputs 127 and −128.
- Backpressure:
  - Stimulus: `dst_ready`=0, continuous beats.
  - Expected: `src_stall`=1 once count reaches 1 (FIFO_DEPTH=4).
  - Stimulus: upstream ignores the stall and pushes a 5th beat.
  - Expected: `overflow`=1; the first 4 beats drain in order once `dst_ready`=1.
- Stall and reset:
  - Stimulus: `enable`=0 for 5 cycles with 2 beats in flight.
  - Expected: outputs frozen; both beats emerge 3 cycles after `enable`=1 returns.
  - Stimulus: assert `rst` mid-stream.
  - Expected: next cycle `dst_valid`=0, `busy`=0, `overflow`=0.
- ReLU (`SFU_REQUANT_RELU_EN`):
  - Setup: `relu_en`=1, zp=−20; lane value −50.
  - Expected: output −20.
  - With `relu_en`=0: output −50.

Source files
------------

// File: rtl/sfu_requant.sv
`default_nettype none
// ============================================================================
// Module      : sfu_requant
// Description : Per-lane requantization of the SFU bias-add output.
//               Each 32-bit signed lane is multiplied by a signed 16-bit
//               scale, round-shifted right (round half up), offset by a
//               signed zero point and saturated to int8. The eight int8
//               results are packed into one 64-bit word per beat and
//               buffered in a small FIFO with a valid/ready read side.
//
//               Pipeline: S1 multiply, S2 round-shift + zero point,
//               S3 saturate/pack. The three stages advance only when
//               `enable` is high. An S3 beat is pushed into the FIFO on the
//               edge it advances out of S3.
//
//               Optional feature macro: SFU_REQUANT_RELU_EN
//                 defined   -> adds `relu_en`; when set, the lower clamp
//                              bound becomes `zero_point` (quantized ReLU).
//                 undefined -> lower clamp bound is always -128.
//
// Ports       : clk, rst            clock / synchronous active-high reset
//               enable              advance S1..S3
//               src_valid, src_0..7 input beat from the bias-add stage
//               scale, shift,       quasi-static requant parameters
//               zero_point
//               relu_en             (SFU_REQUANT_RELU_EN only)
//               dst_valid/ready     FIFO head handshake
//               dst_data            lane i in bits [8i+7:8i]
//               src_stall           FIFO nearly full, upstream must stop
//               busy                any stage valid or FIFO non-empty
//               overflow            sticky: a beat was dropped (FIFO full)
//
// Revision    : 1.0  initial release
// ============================================================================
module sfu_requant #(
    parameter int LANES      = 8,
    parameter int IN_W       = 32,
    parameter int OUT_W      = 8,
    parameter int SCALE_W    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     src_valid,
    input  logic [IN_W-1:0]          src_0,
    input  logic [IN_W-1:0]          src_1,
    input  logic [IN_W-1:0]          src_2,
    input  logic [IN_W-1:0]          src_3,
    input  logic [IN_W-1:0]          src_4,
    input  logic [IN_W-1:0]          src_5,
    input  logic [IN_W-1:0]          src_6,
    input  logic [IN_W-1:0]          src_7,
    input  logic [SCALE_W-1:0]       scale,
    input  logic [4:0]               shift,
    input  logic [OUT_W-1:0]         zero_point,
`ifdef SFU_REQUANT_RELU_EN
    input  logic                     relu_en,
`endif
    output logic                     dst_valid,
    input  logic                     dst_ready,
    output logic [LANES*OUT_W-1:0]   dst_data,
    output logic                     src_stall,
    output logic                     busy,
    output logic                     overflow
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_prod_w = IN_W + SCALE_W;      // full product width
    localparam int c_acc_w  = c_prod_w + 1;        // headroom for rounding add
    localparam int c_word_w = LANES * OUT_W;
    localparam int c_ptr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w  = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);
    // Room is kept for the three beats that may already be in S1..S3.
    localparam logic [c_cnt_w-1:0] c_stall_thr = c_cnt_w'(FIFO_DEPTH - 3);
    localparam logic [c_ptr_w-1:0] c_ptr_last  = c_ptr_w'(FIFO_DEPTH - 1);

    localparam logic signed [c_acc_w-1:0] c_sat_hi = c_acc_w'(2**(OUT_W-1) - 1);
    localparam logic signed [c_acc_w-1:0] c_sat_lo = c_acc_w'(-(2**(OUT_W-1)));
    localparam logic signed [c_acc_w-1:0] c_one    = c_acc_w'(1);

    // ------------------------------------------------------------------
    // Lane gather
    // ------------------------------------------------------------------
    logic [IN_W-1:0] w_src [LANES];

    assign w_src[0] = src_0;
    assign w_src[1] = src_1;
    assign w_src[2] = src_2;
    assign w_src[3] = src_3;
    assign w_src[4] = src_4;
    assign w_src[5] = src_5;
    assign w_src[6] = src_6;
    assign w_src[7] = src_7;

    // ------------------------------------------------------------------
    // Shared per-beat terms
    // ------------------------------------------------------------------
    logic signed [c_acc_w-1:0] w_half;     // rounding constant 2^(shift-1)
    logic signed [c_acc_w-1:0] w_zp_ext;   // sign-extended zero point
    logic signed [c_acc_w-1:0] w_lo;       // lower clamp bound

    assign w_half   = (shift == 5'd0) ? '0 : (c_one <<< (shift - 5'd1));
    assign w_zp_ext = {{(c_acc_w-OUT_W){zero_point[OUT_W-1]}}, zero_point};

`ifdef SFU_REQUANT_RELU_EN
    assign w_lo = relu_en ? w_zp_ext : c_sat_lo;
`else
    assign w_lo = c_sat_lo;
`endif

    // ------------------------------------------------------------------
    // Pipeline storage
    // ------------------------------------------------------------------
    logic                       r_s1_valid;
    logic                       r_s2_valid;
    logic                       r_s3_valid;
    logic signed [c_prod_w-1:0] r_s1_prod [LANES];
    logic signed [c_acc_w-1:0]  r_s2_v    [LANES];
    logic [c_word_w-1:0]        r_s3_data;

    logic signed [c_prod_w-1:0] w_prod    [LANES];
    logic signed [c_acc_w-1:0]  w_v       [LANES];
    logic [c_word_w-1:0]        w_packed;

    // ------------------------------------------------------------------
    // Per-lane datapath
    // ------------------------------------------------------------------
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [c_acc_w-1:0] w_acc;
        logic signed [c_acc_w-1:0] w_rnd;
        logic [OUT_W-1:0]          w_sat;

        // Both operands widened to the product width so the multiply is
        // evaluated at full precision.
        assign w_prod[g] = $signed({{SCALE_W{w_src[g][IN_W-1]}}, w_src[g]})
                         * $signed({{IN_W{scale[SCALE_W-1]}}, scale});

        // With shift == 0 the rounding constant is zero, so the same
        // expression yields r = p.
        assign w_acc  = $signed({r_s1_prod[g][c_prod_w-1], r_s1_prod[g]}) + w_half;
        assign w_rnd  = w_acc >>> shift;
        assign w_v[g] = w_rnd + w_zp_ext;

        always_comb begin
            if (r_s2_v[g] > c_sat_hi) begin
                w_sat = c_sat_hi[OUT_W-1:0];
            end else if (r_s2_v[g] < w_lo) begin
                w_sat = w_lo[OUT_W-1:0];
            end else begin
                w_sat = r_s2_v[g][OUT_W-1:0];
            end
        end

        assign w_packed[g*OUT_W +: OUT_W] = w_sat;
    end

    // ------------------------------------------------------------------
    // Stage valids
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else if (enable) begin
            r_s1_valid <= src_valid;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
        end
    end

    // Stage data needs no reset: it is only ever qualified by the valids.
    always_ff @(posedge clk) begin
        if (enable) begin
            for (int i = 0; i < LANES; i++) begin
                r_s1_prod[i] <= w_prod[i];
                r_s2_v[i]    <= w_v[i];
            end
            r_s3_data <= w_packed;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [c_word_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_stall;
    logic                r_overflow;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_wr;
    logic [c_cnt_w-1:0]  w_count_next;

    assign w_push = enable && r_s3_valid;
    assign w_pop  = dst_valid && dst_ready;
    assign w_full = (r_count == c_depth);
    // A full FIFO still accepts a push when the head leaves on the same
    // edge; the freed slot is the one the write pointer is sitting on.
    assign w_wr   = w_push && (!w_full || w_pop);

    always_comb begin
        w_count_next = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_next = r_count + c_cnt_w'(1);
            2'b01:   w_count_next = r_count - c_cnt_w'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_s3_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= w_count_next;
            r_stall <= (w_count_next >= c_stall_thr);
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dst_valid = (r_count != '0);
    // Masked so the unreset storage never shows on the port while empty.
    assign dst_data  = dst_valid ? r_mem[r_rd_ptr] : '0;
    assign src_stall = r_stall;
    assign overflow  = r_overflow;
    assign busy      = r_s1_valid | r_s2_valid | r_s3_valid | dst_valid;

endmodule
`default_nettype wire

// File: tb/tb_sfu_requant.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfu_requant
// Description : Self-checking bench for sfu_requant. A behavioural model
//               (requant arithmetic on 64-bit integers, a list of in-flight
//               beats with their age in enabled cycles, and a queue for the
//               output FIFO) predicts every output. Directed scenarios cover
//               the documented examples; a randomized scenario mixes
//               enable, valid and ready patterns.
//               Build with SFU_REQUANT_RELU_EN defined to cover relu_en.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sfu_requant;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        src_valid;
    logic [31:0] src [8];
    logic [15:0] scale;
    logic [4:0]  shift;
    logic [7:0]  zero_point;
`ifdef SFU_REQUANT_RELU_EN
    logic        relu_en;
`endif
    logic        dst_valid;
    logic        dst_ready;
    logic [63:0] dst_data;
    logic        src_stall;
    logic        busy;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sfu_requant #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .src_valid  (src_valid),
        .src_0      (src[0]),
        .src_1      (src[1]),
        .src_2      (src[2]),
        .src_3      (src[3]),
        .src_4      (src[4]),
        .src_5      (src[5]),
        .src_6      (src[6]),
        .src_7      (src[7]),
        .scale      (scale),
        .shift      (shift),
        .zero_point (zero_point),
`ifdef SFU_REQUANT_RELU_EN
        .relu_en    (relu_en),
`endif
        .dst_valid  (dst_valid),
        .dst_ready  (dst_ready),
        .dst_data   (dst_data),
        .src_stall  (src_stall),
        .busy       (busy),
        .overflow   (overflow)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [63:0] w;
        int          age;
    } beat_t;

    beat_t       infl [$];
    logic [63:0] exp_q [$];
    bit          m_ovf = 1'b0;

    function automatic logic [7:0] ref_lane(logic [31:0] x);
        longint p;
        longint v;
        longint lo;
        p = longint'($signed(x)) * longint'($signed(scale));
        if (shift != 5'd0)
            p = (p + (longint'(1) <<< (shift - 5'd1))) >>> shift;
        v  = p + longint'($signed(zero_point));
        lo = -128;
`ifdef SFU_REQUANT_RELU_EN
        if (relu_en) lo = longint'($signed(zero_point));
`endif
        if (v > 127)     v = 127;
        else if (v < lo) v = lo;
        return v[7:0];
    endfunction

    function automatic logic [63:0] ref_word();
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = ref_lane(src[i]);
        return w;
    endfunction

    // One clock: model update alongside the DUT edge, return at negedge.
    task automatic tick();
        int  pre;
        bit  pop;
        @(posedge clk);
        if (rst) begin
            infl.delete();
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            pre = exp_q.size();
            pop = (pre > 0) && dst_ready;
            if (pop) void'(exp_q.pop_front());
            if (enable) begin
                for (int i = 0; i < infl.size(); i++) infl[i].age = infl[i].age + 1;
                if (infl.size() > 0 && infl[0].age == 3) begin
                    beat_t b;
                    b = infl.pop_front();
                    if (pre < DEPTH || pop) exp_q.push_back(b.w);
                    else                    m_ovf = 1'b1;
                end
                if (src_valid) infl.push_back('{w: ref_word(), age: 0});
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 0) src[i] = $urandom;
            else                           src[i] = 32'($urandom_range(0, 2000)) - 32'd1000;
        end
    endtask

    task automatic drain();
        enable    = 1'b1;
        src_valid = 1'b0;
        dst_ready = 1'b1;
        for (int i = 0; i < 40 && (infl.size() > 0 || exp_q.size() > 0); i++) tick();
    endtask

    // Drive one beat with the current lanes, then wait (bounded) for the
    // FIFO head. lat counts edges after the capture edge.
    task automatic send_and_wait(output logic [63:0] data, output int lat, output bit got);
        got       = 1'b0;
        lat       = 0;
        data      = '0;
        enable    = 1'b1;
        src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
        for (int i = 1; i <= 10 && !got; i++) begin
            tick();
            if (dst_valid === 1'b1) begin
                got  = 1'b1;
                lat  = i;
                data = dst_data;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({dst_valid, src_stall, busy, overflow, dst_data} !== 68'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b stall=%b busy=%b ovf=%b data=%h, want all 0",
                     dst_valid, src_stall, busy, overflow, dst_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] d;
        int          lat;
        bit          got;
        drain();
        scale = 16'd1; shift = 5'd0; zero_point = 8'd0;
        for (int i = 0; i < 8; i++) src[i] = 32'(i - 4);
        send_and_wait(d, lat, got);
        checks++;
        if (!got || lat != 3) begin
            errors++;
            $display("FAIL basic_latency: got seen=%0d lat=%0d, want seen=1 lat=3", got, lat);
        end
        checks++;
        if (d !== 64'h03020100FFFEFDFC) begin
            errors++;
            $display("FAIL basic_data: got %h want 03020100fffefdfc", d);
        end
        tick();
        checks++;
        if (dst_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_pop: got valid=%b busy=%b, want 0 0", dst_valid, busy);
        end
    endtask

    task automatic test_rounding();
        logic [63:0] d;
        int          lat;
        bit          got;
        drain();
        scale = 16'd3; shift = 5'd2; zero_point = 8'd0;
        src[0] = 32'd5; src[1] = -32'sd5; src[2] = 32'd6; src[3] = 32'd2;
        for (int i = 4; i < 8; i++) src[i] = '0;
        send_and_wait(d, lat, got);
        checks++;
        if (!got || d !== 64'h000000000205FC04) begin
            errors++;
            $display("FAIL rounding: got seen=%0d data=%h want 000000000205fc04", got, d);
        end
    endtask

    task automatic test_saturation();
        logic [63:0] d;
        int          lat;
        bit          got;
        drain();
        scale = 16'h7FFF; shift = 5'd0; zero_point = 8'd10;
        src[0] = 32'd1000; src[1] = -32'sd1000;
        for (int i = 2; i < 8; i++) src[i] = '0;
        send_and_wait(d, lat, got);
        checks++;
        if (!got || d !== 64'h0A0A0A0A0A0A807F) begin
            errors++;
            $display("FAIL saturation: got seen=%0d data=%h want 0a0a0a0a0a0a807f", got, d);
        end
    endtask

    task automatic test_relu();
        logic [63:0] d;
        int          lat;
        bit          got;
        drain();
        scale = 16'd1; shift = 5'd0; zero_point = 8'hEC;   // -20
        for (int i = 0; i < 8; i++) src[i] = -32'sd30;      // v = -50
`ifdef SFU_REQUANT_RELU_EN
        relu_en = 1'b1;
        send_and_wait(d, lat, got);
        checks++;
        if (!got || d !== 64'hECECECECECECECEC) begin
            errors++;
            $display("FAIL relu_on: got seen=%0d data=%h want ecececececececec", got, d);
        end
        drain();
        relu_en = 1'b0;
`endif
        send_and_wait(d, lat, got);
        checks++;
        if (!got || d !== 64'hCECECECECECECECE) begin
            errors++;
            $display("FAIL relu_off: got seen=%0d data=%h want cececececececece", got, d);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_w [5];
        drain();
        scale = 16'd257; shift = 5'd3; zero_point = 8'd5;
        dst_ready = 1'b0;
        enable    = 1'b1;
        for (int t = 0; t < 8; t++) begin
            if (t < 5) begin
                rand_lanes();
                exp_w[t]  = ref_word();
                src_valid = 1'b1;
            end else begin
                src_valid = 1'b0;
            end
            tick();
            checks++;
            if (src_stall !== (exp_q.size() >= DEPTH - 3) || dst_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL bp_stall_t%0d: got stall=%b valid=%b, want stall=%b valid=%b",
                         t, src_stall, dst_valid, exp_q.size() >= DEPTH - 3, exp_q.size() != 0);
            end
        end
        checks++;
        if (overflow !== 1'b1 || src_stall !== 1'b1) begin
            errors++;
            $display("FAIL bp_overflow: got ovf=%b stall=%b, want 1 1", overflow, src_stall);
        end
        dst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dst_valid !== 1'b1 || dst_data !== exp_w[k]) begin
                errors++;
                $display("FAIL bp_drain_%0d: got valid=%b data=%h, want 1 %h", k, dst_valid, dst_data, exp_w[k]);
            end
            tick();
        end
        checks++;
        if (dst_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_empty: got valid=%b ovf=%b, want 0 1", dst_valid, overflow);
        end
    endtask

    task automatic test_stall_reset();
        logic [63:0] wa;
        logic [63:0] wb;
        drain();
        scale = 16'hFF10; shift = 5'd4; zero_point = 8'hF0;
        dst_ready = 1'b1;
        enable    = 1'b1;
        src_valid = 1'b1;
        rand_lanes(); wa = ref_word(); tick();
        rand_lanes(); wb = ref_word(); tick();
        enable = 1'b0;
        for (int t = 0; t < 5; t++) begin
            rand_lanes();                      // must be ignored
            tick();
            checks++;
            if (dst_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL frozen_t%0d: got valid=%b busy=%b, want 0 1", t, dst_valid, busy);
            end
        end
        enable    = 1'b1;
        src_valid = 1'b0;
        tick();
        checks++;
        if (dst_valid !== 1'b0) begin
            errors++;
            $display("FAIL resume_1: got valid=%b want 0", dst_valid);
        end
        tick();
        checks++;
        if (dst_valid !== 1'b1 || dst_data !== wa) begin
            errors++;
            $display("FAIL resume_2: got valid=%b data=%h, want 1 %h", dst_valid, dst_data, wa);
        end
        tick();
        checks++;
        if (dst_valid !== 1'b1 || dst_data !== wb) begin
            errors++;
            $display("FAIL resume_3: got valid=%b data=%h, want 1 %h", dst_valid, dst_data, wb);
        end

        // Mid-stream reset with a full FIFO, overflow set and beats in flight.
        dst_ready = 1'b0;
        src_valid = 1'b1;
        for (int t = 0; t < 9; t++) begin
            rand_lanes();
            tick();
        end
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL prereset: got ovf=%b busy=%b, want 1 1", overflow, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({dst_valid, busy, overflow, src_stall} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset: got valid=%b busy=%b ovf=%b stall=%b, want 0 0 0 0",
                     dst_valid, busy, overflow, src_stall);
        end
        src_valid = 1'b0;
        dst_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++;
            if (dst_valid !== 1'b0) begin
                errors++;
                $display("FAIL postreset_t%0d: got valid=%b want 0", t, dst_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] want_d;
        for (int round = 0; round < 4; round++) begin
            drain();
            scale      = 16'($urandom);
            shift      = 5'($urandom_range(0, 31));
            zero_point = 8'($urandom);
`ifdef SFU_REQUANT_RELU_EN
            relu_en    = 1'($urandom_range(0, 1));
`endif
            for (int t = 0; t < 200; t++) begin
                enable    = ($urandom_range(0, 3) != 0);
                src_valid = 1'($urandom_range(0, 1));
                dst_ready = (round == 3) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
                rand_lanes();
                tick();
                want_d = (exp_q.size() > 0) ? exp_q[0] : 64'd0;
                checks++;
                if (dst_valid !== (exp_q.size() != 0) || dst_data !== want_d ||
                    busy !== (infl.size() > 0 || exp_q.size() > 0) ||
                    src_stall !== (exp_q.size() >= DEPTH - 3) || overflow !== m_ovf) begin
                    errors++;
                    $display("FAIL random_r%0d_t%0d: got v=%b d=%h busy=%b stall=%b ovf=%b, want v=%b d=%h busy=%b stall=%b ovf=%b",
                             round, t, dst_valid, dst_data, busy, src_stall, overflow,
                             exp_q.size() != 0, want_d, infl.size() > 0 || exp_q.size() > 0,
                             exp_q.size() >= DEPTH - 3, m_ovf);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    initial begin
        rst        = 1'b1;
        enable     = 1'b1;
        src_valid  = 1'b0;
        dst_ready  = 1'b1;
        scale      = 16'd1;
        shift      = 5'd0;
        zero_point = 8'd0;
`ifdef SFU_REQUANT_RELU_EN
        relu_en    = 1'b0;
`endif
        for (int i = 0; i < 8; i++) src[i] = '0;

        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_relu();
        test_backpressure();
        test_stall_reset();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
